// File: rtl/serial_arith_pkg.sv
// rtl/serial_arith_pkg.sv - shared constants for the bit-serial arithmetic blocks
package serial_arith_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - request/result handshake bundle of the serial subtractor
interface serial_subtractor_if #(parameter int WIDTH = 4);

  logic             START;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             BIN;
  logic             BUSY;
  logic [WIDTH-1:0] DIFF;
  logic             BOUT;
  logic             VALID;
  logic             READY;

  modport master (
    output START, A, B, BIN, READY,
    input  BUSY, DIFF, BOUT, VALID
  );

  modport slave (
    input  START, A, B, BIN, READY,
    output BUSY, DIFF, BOUT, VALID
  );

endinterface

// File: rtl/full_subtractor_bit.sv
// rtl/full_subtractor_bit.sv - one-bit full subtractor, combinational
module full_subtractor_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial A - B - BIN, LSB first, VALID/READY result
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               CLK,
  input  logic               RST_N,
  serial_subtractor_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] diff_sr;
  logic             br;
  logic             bout_q;
  logic             busy_q;
  logic             valid_q;
  logic [CNT_W-1:0] cnt;
  logic             d_bit;
  logic             br_next;

  full_subtractor_bit u_fsb (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (br),
    .d    (d_bit),
    .bout (br_next)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      diff_sr <= '0;
      br      <= 1'b0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.START) begin
            a_sr   <= bus.A;
            b_sr   <= bus.B;
            br     <= bus.BIN;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          diff_sr <= {d_bit, diff_sr[WIDTH-1:1]};
          br      <= br_next;
          cnt     <= cnt + CNT_W'(1);
          // Last bit: borrow-out becomes visible together with VALID.
          if (cnt == CNT_W'(WIDTH - 1)) begin
            bout_q  <= br_next;
            valid_q <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          if (bus.READY) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.BUSY  = busy_q;
  assign bus.VALID = valid_q;
  assign bus.DIFF  = diff_sr;
  assign bus.BOUT  = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - randomized self-checking bench for serial_subtractor
module tb_serial_subtractor;

  localparam int WIDTH = 4;

  logic CLK = 1'b0;
  logic RST_N;
  int   errors = 0;
  int   checks = 0;

  serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain unsigned arithmetic on the operands.
  function automatic logic [WIDTH-1:0] ref_diff(input int a, input int b, input int bin);
    int r;
    r = (a - b - bin) % (1 << WIDTH);
    if (r < 0) r += (1 << WIDTH);
    return WIDTH'(r);
  endfunction

  function automatic logic ref_bout(input int a, input int b, input int bin);
    return (a < b + bin);
  endfunction

  // Issue one operation starting at a negedge in IDLE; returns at a negedge in IDLE.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin,
                        input int hold, input bit junk, input bit start_on_accept);
    int cycles;
    logic [WIDTH-1:0] ed;
    logic eb;
    ed = ref_diff(int'(a), int'(b), int'(bin));
    eb = ref_bout(int'(a), int'(b), int'(bin));
    bus.START = 1'b1; bus.A = a; bus.B = b; bus.BIN = bin; bus.READY = 1'b0;
    @(posedge CLK); @(negedge CLK);
    bus.START = 1'b0;
    cycles = 0;
    while (!bus.VALID && cycles < 50) begin
      check_val("busy_run", bus.BUSY, 1'b1);
      if (junk && cycles == 1) begin
        bus.START = 1'b1; bus.A = '1; bus.B = '0; bus.BIN = 1'b0;
      end else begin
        bus.START = 1'b0;
      end
      @(posedge CLK); @(negedge CLK);
      cycles++;
    end
    bus.START = 1'b0;
    check_val("valid_latency", cycles, WIDTH);
    check_val("diff", bus.DIFF, ed);
    check_val("bout", bus.BOUT, eb);
    check_val("busy_done", bus.BUSY, 1'b1);
    for (int i = 0; i < hold; i++) begin
      bus.START = (junk && i == 0);
      bus.A = '1; bus.B = '0;
      @(posedge CLK); @(negedge CLK);
      check_val("valid_hold", bus.VALID, 1'b1);
      check_val("diff_hold", bus.DIFF, ed);
      check_val("bout_hold", bus.BOUT, eb);
    end
    bus.READY = 1'b1;
    bus.START = start_on_accept;
    bus.A = ~a; bus.B = b; bus.BIN = ~bin;
    @(posedge CLK); @(negedge CLK);
    bus.READY = 1'b0;
    bus.START = 1'b0;
    check_val("valid_after_ack", bus.VALID, 1'b0);
    check_val("busy_after_ack", bus.BUSY, 1'b0);
    check_val("diff_idle", bus.DIFF, ed);
    check_val("bout_idle", bus.BOUT, eb);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.START = 1'b0; bus.A = '0; bus.B = '0; bus.BIN = 1'b0; bus.READY = 1'b0;
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    check_val("rst_busy", bus.BUSY, 1'b0);
    check_val("rst_valid", bus.VALID, 1'b0);
    check_val("rst_diff", bus.DIFF, '0);
    check_val("rst_bout", bus.BOUT, 1'b0);
    RST_N = 1'b1;
    @(negedge CLK);

    run_op(4'b0101, 4'b0010, 1'b0, 0, 1'b0, 1'b0);
    run_op(4'b0001, 4'b0011, 1'b1, 0, 1'b0, 1'b0);
    run_op(4'b0000, 4'b0000, 1'b1, 0, 1'b0, 1'b0);
    run_op(4'b1001, 4'b0100, 1'b0, 10, 1'b1, 1'b0);

    // Reset during the second RUN cycle aborts asynchronously.
    bus.START = 1'b1; bus.A = 4'b0110; bus.B = 4'b0001; bus.BIN = 1'b0;
    @(posedge CLK); @(negedge CLK);
    bus.START = 1'b0;
    @(posedge CLK); #2;
    RST_N = 1'b0;
    #1;
    check_val("arst_busy", bus.BUSY, 1'b0);
    check_val("arst_valid", bus.VALID, 1'b0);
    check_val("arst_diff", bus.DIFF, '0);
    check_val("arst_bout", bus.BOUT, 1'b0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    check_val("arst_idle_busy", bus.BUSY, 1'b0);
    run_op(4'b1111, 4'b1111, 1'b0, 0, 1'b0, 1'b0);

    // START during the accepting cycle is dropped; next cycle's START is taken.
    run_op(4'b0111, 4'b1000, 1'b0, 1, 1'b0, 1'b1);
    run_op(4'b1100, 4'b0011, 1'b1, 0, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) begin
        bus.READY = 1'($urandom);
        @(negedge CLK);
        check_val("idle_busy", bus.BUSY, 1'b0);
        check_val("idle_valid", bus.VALID, 1'b0);
      end
      bus.READY = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial WIDTH-bit subtractor computing {BOUT, DIFF} = A − B − BIN, LSB first, one bit per clock. It is the subtract counterpart of the team's parallel adder, for area-constrained datapaths that can absorb multi-cycle latency. It captures operands on a START pulse and presents the result through a VALID/READY output handshake.

## Interface
Parameters:
- WIDTH, 4, operand and result width in bits (≥ 2)

Ports:
- CLK  input  1  single clock, rising-edge
- RST_N  input  1  reset, asynchronous assert, active-low
- START  input  1  request; sampled only in IDLE
- A  input  WIDTH  minuend, captured on accepted START
- B  input  WIDTH  subtrahend, captured on accepted START
- BIN  input  1  borrow-in, captured on accepted START
- BUSY  output  1  high in RUN and DONE
- DIFF  output  WIDTH  difference, (A − B − BIN) mod 2^WIDTH
- BOUT  output  1  borrow-out; 1 iff A < B + BIN (unsigned)
- VALID  output  1  DIFF/BOUT valid; high in DONE only
- READY  input  1  consumer accepts the result when VALID && READY

## Operation
- One clock; reset is asynchronous and active-low. On RST_N low: state IDLE, BUSY=0, VALID=0, DIFF=0, BOUT=0, bit counter=0, operand registers=0.
- FSM states:
  - IDLE → RUN when START=1. Capture A, B, and BIN (as the initial borrow). Clear the counter.
  - RUN: each cycle, process bit a0/b0 (LSB of the shift registers) with borrow br:
    - d = a0 ^ b0 ^ br
    - br' = (~a0 & b0) | (~(a0 ^ b0) & br)
    - Shift the A/B registers right. Shift d into the MSB of the DIFF register. Increment the counter.
    - After the WIDTH-th bit → DONE; BOUT takes the final br'.
  - DONE: VALID=1. DIFF and BOUT are held stable. When READY=1 → IDLE.
- START is ignored in RUN and DONE, including a START in the same cycle as the accepting READY. No back-to-back issue: the next START is accepted in IDLE at the earliest.
- In IDLE, DIFF and BOUT keep the last result until the next accepted START.
- During RUN, DIFF holds partial shift contents, and BOUT holds its previous value until the final bit is processed. Consumers must qualify both with VALID.
- READY outside DONE has no effect.
- Wrap-around: the result is modulo 2^WIDTH; underflow is reported only via BOUT.
- Reset asserted mid-RUN or in DONE aborts immediately to the reset values. No partial result is retained.

## Timing
- Edge E0 samples START=1 in IDLE. Edges E1..EWIDTH process bits 0..WIDTH−1.
- The state enters DONE at edge EWIDTH, so VALID rises WIDTH cycles after the accepting edge (4 cycles at default).
- Handshake completes at the first rising edge with VALID && READY. VALID falls and BUSY falls on that same edge.
- Minimum START-to-START spacing: WIDTH + 2 cycles (WIDTH RUN, ≥1 DONE, 1 IDLE).
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package serial_arith_pkg: state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH constant. This package is reused by future serial arithmetic blocks.
- One natural sub-module: full_subtractor_bit (inputs a, b, bin; outputs d, bout), purely combinational. It is instantiated once inside the RUN datapath.
- The counter is $clog2(WIDTH+1) bits wide.

## Test plan
- A=4'b0101, B=4'b0010, BIN=0, START one cycle, READY=1 → VALID exactly 4 cycles after the accepting edge; DIFF=4'b0011, BOUT=0; BUSY high throughout.
- A=4'b0001, B=4'b0011, BIN=1 → DIFF=4'b1101, BOUT=1.
- A=4'b0000, B=4'b0000, BIN=1 → DIFF=4'b1111, BOUT=1 (wrap-around).
- A=4'b1001, B=4'b0100, BIN=0, READY=0 for 10 cycles after VALID → VALID and DIFF=4'b0101 stay stable. A START with A=4'b1111, B=0 pulsed during RUN and during DONE is ignored, and the result is unchanged. READY=1 → IDLE next edge.
- RST_N low during the 2nd RUN cycle → all outputs 0 immediately (asynchronous), state IDLE. After release, A=4'b1111, B=4'b1111, BIN=0 → DIFF=4'b0000, BOUT=0.
- START held high in the same cycle READY accepts a result → START ignored. START pulsed again one cycle later (in IDLE) → accepted; new VALID 4 cycles after that edge.
